// File: rtl/truth_table_checker.sv
// truth_table_checker
//   Exercises a small combinational circuit by stepping through every input
//   combination in ascending order. Each vector is held for SETTLE idle cycles
//   plus one capture cycle. The sampled response builds a captured truth table,
//   which is compared bit by bit against EXPECTED.
//
// Parameters
//   N_IN      number of circuit inputs; the table depth is 2**N_IN (1..6)
//   SETTLE    idle cycles per vector before the capture cycle (0..15)
//   EXPECTED  expected response per vector index, bit v holds F(v)
//
// Ports
//   i_clk                 rising-edge clock
//   i_rst                 synchronous, active-high reset
//   i_start               begins a run; sampled only in IDLE
//   o_dut_in[N_IN]        registered vector driven to the circuit (MSB = A)
//   i_dut_out             response from the circuit
//   o_busy                high while vectors are being applied (WAIT/CAPT)
//   o_done                one-cycle pulse in FIN
//   o_pass                run result, valid from done until the next start
//   o_captured[2**N_IN]   captured[v] = response sampled for vector v
//   o_mismatch_cnt        number of vectors whose response differs from EXPECTED
//   o_first_fail_idx      lowest failing vector, valid iff o_first_fail_valid
//   o_first_fail_valid    at least one mismatch seen in this run
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; results of the last run are held
// WAIT   | current vector applied, letting the circuit settle
// CAPT   | sample the response for the current vector, then advance
// FIN    | one cycle: done pulse, pass reflects the final count
module truth_table_checker #(
  parameter int unsigned           N_IN     = 3,
  parameter int unsigned           SETTLE   = 2,
  parameter logic [2**N_IN-1:0]    EXPECTED = 8'b1110_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic [N_IN-1:0]      o_dut_in,
  input  logic                 i_dut_out,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [2**N_IN-1:0]   o_captured,
  output logic [N_IN:0]        o_mismatch_cnt,
  output logic [N_IN-1:0]      o_first_fail_idx,
  output logic                 o_first_fail_valid
);

  localparam int unsigned     DEPTH       = 2**N_IN;
  localparam logic [N_IN-1:0] V_LAST      = {N_IN{1'b1}};
  // Last settle count before capture; unused when SETTLE is 0.
  localparam logic [3:0]      SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t            r_state;
  logic [N_IN-1:0]   r_v;
  logic [3:0]        r_settle_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [DEPTH-1:0]  r_captured;
  logic [N_IN:0]     r_mismatch_cnt;
  logic [N_IN-1:0]   r_first_fail_idx;
  logic              r_first_fail_valid;

  logic              w_mis;
  logic [N_IN:0]     w_cnt_next;

  assign w_mis      = (i_dut_out != EXPECTED[r_v]);
  // Count including the vector being captured this cycle, so the last
  // vector's result is already reflected in pass when FIN is entered.
  assign w_cnt_next = r_mismatch_cnt + {{N_IN{1'b0}}, w_mis};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state            <= S_IDLE;
      r_v                <= '0;
      r_settle_cnt       <= '0;
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
      r_pass             <= 1'b0;
      r_captured         <= '0;
      r_mismatch_cnt     <= '0;
      r_first_fail_idx   <= '0;
      r_first_fail_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_captured         <= '0;
            r_mismatch_cnt     <= '0;
            r_first_fail_idx   <= '0;
            r_first_fail_valid <= 1'b0;
            r_pass             <= 1'b0;
            r_v                <= '0;
            r_settle_cnt       <= '0;
            r_busy             <= 1'b1;
            r_state            <= (SETTLE == 0) ? S_CAPT : S_WAIT;
          end
        end

        S_WAIT: begin
          r_settle_cnt <= r_settle_cnt + 4'd1;
          if (r_settle_cnt == SETTLE_LAST) begin
            r_state <= S_CAPT;
          end
        end

        S_CAPT: begin
          r_captured[r_v] <= i_dut_out;
          r_mismatch_cnt  <= w_cnt_next;
          if (w_mis && !r_first_fail_valid) begin
            r_first_fail_idx   <= r_v;
            r_first_fail_valid <= 1'b1;
          end
          if (r_v == V_LAST) begin
            r_v     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_cnt_next == '0);
            r_state <= S_FIN;
          end else begin
            r_v          <= r_v + 1'b1;
            r_settle_cnt <= '0;
            r_state      <= (SETTLE == 0) ? S_CAPT : S_WAIT;
          end
        end

        S_FIN: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_dut_in           = r_v;
  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_pass             = r_pass;
  assign o_captured         = r_captured;
  assign o_mismatch_cnt     = r_mismatch_cnt;
  assign o_first_fail_idx   = r_first_fail_idx;
  assign o_first_fail_valid = r_first_fail_valid;

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_s = 1'b0;
  logic start_f = 1'b0;
  int   mode = 0;
  int   sel  = 0;

  int n_tests = 0;
  int n_fail  = 0;

  // Slow instance (SETTLE=2)
  logic [2:0] dut_in_s;
  logic       dut_out_s, busy_s, done_s, pass_s, ffv_s;
  logic [7:0] cap_s;
  logic [3:0] cnt_s;
  logic [2:0] ffi_s;

  // Fast instance (SETTLE=0)
  logic [2:0] dut_in_f;
  logic       dut_out_f, busy_f, done_f, pass_f, ffv_f;
  logic [7:0] cap_f;
  logic [3:0] cnt_f;
  logic [2:0] ffi_f;

  // Outputs of the instance currently under observation
  logic [2:0] o_dut_in;
  logic       o_busy, o_done, o_pass, o_ffv;
  logic [7:0] o_cap;
  logic [3:0] o_cnt;
  logic [2:0] o_ffi;

  always #5 clk = ~clk;

  function automatic logic f_model(input int m, input logic [2:0] v);
    case (m)
      0:       return v[2] & (v[1] | v[0]);
      1:       return 1'b0;
      default: return v[2] & v[1];
    endcase
  endfunction

  function automatic logic f_golden(input logic [2:0] v);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    return a & (b | c);
  endfunction

  always_comb dut_out_s = f_model(mode, dut_in_s);
  always_comb dut_out_f = f_model(mode, dut_in_f);

  always_comb begin
    o_dut_in = dut_in_s; o_busy = busy_s; o_done = done_s; o_pass = pass_s;
    o_ffv = ffv_s; o_cap = cap_s; o_cnt = cnt_s; o_ffi = ffi_s;
    if (sel != 0) begin
      o_dut_in = dut_in_f; o_busy = busy_f; o_done = done_f; o_pass = pass_f;
      o_ffv = ffv_f; o_cap = cap_f; o_cnt = cnt_f; o_ffi = ffi_f;
    end
  end

  truth_table_checker #(.N_IN(3), .SETTLE(2), .EXPECTED(8'b1110_0000)) u_slow (
    .i_clk(clk), .i_rst(rst), .i_start(start_s),
    .o_dut_in(dut_in_s), .i_dut_out(dut_out_s),
    .o_busy(busy_s), .o_done(done_s), .o_pass(pass_s),
    .o_captured(cap_s), .o_mismatch_cnt(cnt_s),
    .o_first_fail_idx(ffi_s), .o_first_fail_valid(ffv_s)
  );

  truth_table_checker #(.N_IN(3), .SETTLE(0), .EXPECTED(8'b1110_0000)) u_fast (
    .i_clk(clk), .i_rst(rst), .i_start(start_f),
    .o_dut_in(dut_in_f), .i_dut_out(dut_out_f),
    .o_busy(busy_f), .o_done(done_f), .o_pass(pass_f),
    .o_captured(cap_f), .o_mismatch_cnt(cnt_f),
    .o_first_fail_idx(ffi_f), .o_first_fail_valid(ffv_f)
  );

  typedef struct {
    logic [7:0] cap;
    logic [3:0] cnt;
    logic [2:0] ffi;
    logic       ffv;
    logic       pass;
    int         lat;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t make_exp(input int m, input int settle);
    exp_t e;
    e.cap = '0; e.cnt = '0; e.ffi = '0; e.ffv = 1'b0;
    for (int v = 0; v < 8; v++) begin
      logic r;
      r = f_model(m, 3'(v));
      e.cap[v] = r;
      if (r != f_golden(3'(v))) begin
        e.cnt = e.cnt + 4'd1;
        if (!e.ffv) begin
          e.ffi = 3'(v);
          e.ffv = 1'b1;
        end
      end
    end
    e.pass = (e.cnt == 0);
    e.lat  = 8 * (settle + 1) + 1;
    return e;
  endfunction

  // One run on instance inst with circuit model m. With hold, start stays
  // high for the whole window and the bench returns while a second run is
  // in progress (about 10 cycles in).
  task automatic run(input int inst, input int m, input bit hold);
    int settle, win, done_k, ndone, seq_err, busy_err;
    exp_t e, got;
    sel     = inst;
    mode    = m;
    settle  = (inst != 0) ? 0 : 2;
    e       = make_exp(m, settle);
    sb.push_back(e);
    win     = hold ? 36 : 40;
    done_k  = -1; ndone = 0; seq_err = 0; busy_err = 0;
    @(negedge clk);
    if (inst != 0) start_f = 1'b1; else start_s = 1'b1;
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      if (!hold) begin
        start_s = 1'b0;
        start_f = 1'b0;
      end
      if (k < e.lat) begin
        if (o_dut_in !== 3'((k - 1) / (settle + 1))) seq_err++;
        if (o_busy !== 1'b1) busy_err++;
      end else if (k == e.lat) begin
        if (o_busy !== 1'b0) busy_err++;
      end
      if (o_done === 1'b1) begin
        ndone++;
        if (done_k < 0) begin
          done_k = k;
          if (sb.size() > 0) begin
            got = sb.pop_front();
            chk("captured", 32'(o_cap), 32'(got.cap));
            chk("mismatch_cnt", 32'(o_cnt), 32'(got.cnt));
            chk("first_fail_idx", 32'(o_ffi), 32'(got.ffi));
            chk("first_fail_valid", 32'(o_ffv), 32'(got.ffv));
            chk("pass", 32'(o_pass), 32'(got.pass));
          end
        end
      end
    end
    chk("done_latency", 32'(done_k), 32'(e.lat));
    chk("done_count", 32'(ndone), 32'd1);
    chk("dut_in_sequence_errors", 32'(seq_err), 32'd0);
    chk("busy_errors", 32'(busy_err), 32'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    if (!hold) begin
      chk("held_captured", 32'(o_cap), 32'(e.cap));
      chk("held_pass", 32'(o_pass), 32'(e.pass));
    end
  endtask

  initial begin
    int late_done;
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sel = 0;
    chk("rst_dut_in", 32'(o_dut_in), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_pass", 32'(o_pass), 32'd0);
    chk("rst_captured", 32'(o_cap), 32'd0);
    chk("rst_mismatch_cnt", 32'(o_cnt), 32'd0);
    chk("rst_first_fail_idx", 32'(o_ffi), 32'd0);
    chk("rst_first_fail_valid", 32'(o_ffv), 32'd0);
    chk("rst_fast_busy", 32'(busy_f), 32'd0);
    rst = 1'b0;

    run(0, 0, 1'b0);   // correct circuit
    run(0, 1, 1'b0);   // output stuck at 0
    run(0, 2, 1'b0);   // faulty F = A&B

    // start held high, then reset mid-way through the re-triggered run
    run(0, 0, 1'b1);
    chk("retrigger_busy", 32'(o_busy), 32'd1);
    start_s = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_dut_in", 32'(o_dut_in), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    late_done = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (o_done === 1'b1) late_done++;
    end
    chk("abort_no_done", 32'(late_done), 32'd0);

    run(1, 0, 1'b0);   // SETTLE=0, correct circuit
    run(1, 2, 1'b0);   // SETTLE=0, faulty circuit

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
